// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Sequential instruction-supply front end for the LEGv8 datapath. Owns the
//   program counter, fetches 32-bit words over a req/ack memory handshake and
//   hands each word (with its PC and opcode field) to decode over valid/ready.
//   Taken branches from execute redirect the PC; wrong-path words are dropped.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   imem_req/imem_addr   fetch request and address (address stable while req)
//   imem_ack/imem_rdata  memory completion and returned word
//   instr_valid/ready    delivery handshake to decode
//   instr/opcode/instr_pc held word, its [31:21] field, and its fetch address
//   branch_taken/target  one-cycle redirect pulse and target address
//   fetch_count          number of completed deliveries (wraps)
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [10:0]       opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n;
    logic              squash, squash_n;
    logic [31:0]       instr_q, instr_n;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_n;
    logic [31:0]       count_q, count_n;
    logic [ADDR_W-1:0] target;

    // Word-aligned redirect address.
    assign target = branch_target & ~ADDR_W'(3);

    // While a squashed request is outstanding, pc already holds the redirect
    // address; the in-flight request keeps presenting the address it was
    // issued with (captured in req_addr).
    assign imem_addr   = squash ? req_addr : pc;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:21];
    assign instr_pc    = instr_pc_q;
    assign fetch_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            squash     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            squash     <= squash_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            count_q    <= count_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        squash_n    = squash;
        instr_n     = instr_q;
        instr_pc_n  = instr_pc_q;
        count_n     = count_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state)
            IDLE: begin
                if (branch_taken) begin
                    pc_n = target;
                end
                state_n = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (squash || branch_taken) begin
                        // Wrong-path data: discard and reissue at the redirect.
                        squash_n = 1'b0;
                        if (branch_taken) begin
                            pc_n = target;
                        end
                    end else begin
                        instr_n    = imem_rdata;
                        instr_pc_n = pc;
                        pc_n       = pc + ADDR_W'(4);
                        state_n    = HOLD;
                    end
                end else if (branch_taken) begin
                    // Request cannot be withdrawn: keep its address, remember
                    // the newest target, and drop the data when it arrives.
                    if (!squash) begin
                        req_addr_n = pc;
                    end
                    pc_n     = target;
                    squash_n = 1'b1;
                end
            end

            HOLD: begin
                instr_valid = 1'b1;
                if (branch_taken) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (instr_ready) begin
                    count_n = count_q + 32'd1;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
